// File: rtl/mips_core_pkg.sv
// Shared core types and the data-cache geometry, states and line layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } MemAccessType;

    localparam int D_CACHE_INDEX_WIDTH    = 5;
    localparam int D_CACHE_WORD_SEL_WIDTH = 2;
    localparam int D_CACHE_TAG_WIDTH      = ADDR_WIDTH - D_CACHE_INDEX_WIDTH
                                            - D_CACHE_WORD_SEL_WIDTH - 2;
    localparam int D_CACHE_LINES          = 1 << D_CACHE_INDEX_WIDTH;
    localparam int D_CACHE_LINE_WORDS     = 1 << D_CACHE_WORD_SEL_WIDTH;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_WAIT = 3'd2,
        WR_REQ      = 3'd3,
        WR_DONE     = 3'd4
    } d_cache_state_t;

    typedef struct packed {
        logic                                              valid;
        logic [D_CACHE_TAG_WIDTH-1:0]                      tag;
        logic [D_CACHE_LINE_WORDS-1:0][DATA_WIDTH-1:0]     data;
    } d_cache_line;

endpackage

// File: rtl/d_cache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Latency: combinational read of one line; word write and tag/valid update on the next clk edge.
// Backpressure: none; always accepts a write, the owner sequences accesses.
// Ports: clk/rst (async clear of all valid bits), rd_index_i -> rd_line_o,
//        wr_en_i/wr_index_i/wr_word_i/wr_data_i word write,
//        set_valid_i/set_tag_i mark a line filled, clr_valid_i invalidates a line.
module d_cache_array
    import mips_core_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [D_CACHE_INDEX_WIDTH-1:0]    rd_index_i,
    output d_cache_line                       rd_line_o,
    input  logic                              wr_en_i,
    input  logic [D_CACHE_INDEX_WIDTH-1:0]    wr_index_i,
    input  logic [D_CACHE_WORD_SEL_WIDTH-1:0] wr_word_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              set_valid_i,
    input  logic [D_CACHE_TAG_WIDTH-1:0]      set_tag_i,
    input  logic                              clr_valid_i
);

    logic [D_CACHE_LINES-1:0]                          valid_q;
    logic [D_CACHE_TAG_WIDTH-1:0]                      tag_q  [D_CACHE_LINES];
    logic [D_CACHE_LINE_WORDS-1:0][DATA_WIDTH-1:0]     data_q [D_CACHE_LINES];

    // Only the valid bits need reset; tag and data are meaningless while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (set_valid_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end else if (clr_valid_i) begin
            valid_q[wr_index_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_valid_i) begin
            tag_q[wr_index_i] <= set_tag_i;
        end
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_line_o.valid = valid_q[rd_index_i];
        rd_line_o.tag   = tag_q[rd_index_i];
        rd_line_o.data  = data_q[rd_index_i];
    end

endmodule

// File: rtl/d_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate blocking data cache answering load/store requests.
// Latency: read hit 1 cycle; miss = 4 memory request/response pairs then a hit; write = memory write + 1 done cycle.
// Backpressure: combinational stall holds the upstream request; mem_req_* held stable until mem_req_ready.
// Ports: req_valid/req_action/req_addr/req_data in, stall out; resp_valid/resp_data registered load result;
//        mem_req_valid/write/addr/wdata with mem_req_ready handshake; mem_rsp_valid/mem_rsp_rdata refill data.
module d_cache_responder
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH     = mips_core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = mips_core_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH    = D_CACHE_INDEX_WIDTH,
    parameter int WORD_SEL_WIDTH = D_CACHE_WORD_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  MemAccessType          req_action,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - WORD_SEL_WIDTH - 2;

    d_cache_state_t              state_q;
    logic [WORD_SEL_WIDTH-1:0]   word_cnt_q;
    logic                        resp_valid_q;
    logic [DATA_WIDTH-1:0]       resp_data_q;
    logic                        mem_req_valid_q;
    logic                        mem_req_write_q;
    logic [ADDR_WIDTH-1:0]       mem_req_addr_q;
    logic [DATA_WIDTH-1:0]       mem_req_wdata_q;

    logic [TAG_WIDTH-1:0]        req_tag;
    logic [INDEX_WIDTH-1:0]      req_index;
    logic [WORD_SEL_WIDTH-1:0]   req_word;
    logic [WORD_SEL_WIDTH-1:0]   word_cnt_nxt;
    logic                        is_read;
    logic                        hit;
    logic [DATA_WIDTH-1:0]       hit_word;
    d_cache_line                 rd_line;

    logic                        refill_wr;
    logic                        write_hit;
    logic                        arr_wr_en;
    logic [WORD_SEL_WIDTH-1:0]   arr_wr_word;
    logic [DATA_WIDTH-1:0]       arr_wr_data;
    logic                        arr_set_valid;
    logic                        arr_clr_valid;

    assign req_tag      = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_index    = req_addr[WORD_SEL_WIDTH+2 +: INDEX_WIDTH];
    assign req_word     = req_addr[2 +: WORD_SEL_WIDTH];
    assign word_cnt_nxt = word_cnt_q + WORD_SEL_WIDTH'(1);
    assign is_read      = (req_action == READ);
    assign hit          = rd_line.valid && (rd_line.tag == req_tag);
    assign hit_word     = rd_line.data[req_word];

    // Both cache writers target the line of the held request.
    assign refill_wr     = (state_q == REFILL_WAIT) && mem_rsp_valid;
    assign write_hit     = (state_q == WR_REQ) && mem_req_ready && hit;
    assign arr_wr_en     = refill_wr || write_hit;
    assign arr_wr_word   = refill_wr ? word_cnt_q : req_word;
    assign arr_wr_data   = refill_wr ? mem_rsp_rdata : req_data;
    assign arr_set_valid = refill_wr && (word_cnt_q == '1);
    // Invalidate the victim at miss start so a partly overwritten line never hits,
    // including after a reset that abandons the refill.
    assign arr_clr_valid = (state_q == IDLE) && req_valid && is_read && !hit;

    d_cache_array u_array (
        .clk         (clk),
        .rst         (rst),
        .rd_index_i  (req_index),
        .rd_line_o   (rd_line),
        .wr_en_i     (arr_wr_en),
        .wr_index_i  (req_index),
        .wr_word_i   (arr_wr_word),
        .wr_data_i   (arr_wr_data),
        .set_valid_i (arr_set_valid),
        .set_tag_i   (req_tag),
        .clr_valid_i (arr_clr_valid)
    );

    // Only an IDLE read hit or the WR_DONE cycle lets the request go.
    always_comb begin
        stall = 1'b1;
        case (state_q)
            IDLE:    stall = req_valid && !(is_read && hit);
            WR_DONE: stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            word_cnt_q      <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (is_read) begin
                            if (hit) begin
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= hit_word;
                            end else begin
                                word_cnt_q      <= '0;
                                state_q         <= REFILL_REQ;
                                mem_req_valid_q <= 1'b1;
                                mem_req_write_q <= 1'b0;
                                mem_req_addr_q  <= {req_tag, req_index, {WORD_SEL_WIDTH{1'b0}}, 2'b00};
                            end
                        end else begin
                            state_q         <= WR_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_write_q <= 1'b1;
                            mem_req_addr_q  <= req_addr & ~ADDR_WIDTH'(3);
                            mem_req_wdata_q <= req_data;
                        end
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (word_cnt_q == '1) begin
                            state_q <= IDLE;
                        end else begin
                            word_cnt_q      <= word_cnt_nxt;
                            state_q         <= REFILL_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {req_tag, req_index, word_cnt_nxt, 2'b00};
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;

endmodule
